// File: rtl/wb_dsp_equation_sequencer_pkg.sv
// Shared field positions and FSM encoding for the DSP equation sequencer.
// Control/status bit layout matches the software-visible register block.
package wb_dsp_equation_sequencer_pkg;

    localparam int NUM_EQ        = 4;

    localparam int CTRL_START    = 0;
    localparam int CTRL_IRQ_EN   = 1;
    localparam int CTRL_ABORT    = 2;
    localparam int CTRL_RSVD     = 3;
    localparam int CTRL_MASK_LSB = 4;
    localparam int CTRL_MASK_MSB = 7;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    localparam int STAT_ERROR    = 2;
    localparam int STAT_ABORTED  = 3;
    localparam int STAT_IDX_LSB  = 4;
    localparam int STAT_IDX_MSB  = 5;
    localparam int STAT_CMPL_LSB = 8;
    localparam int STAT_CMPL_MSB = 11;
    localparam int STAT_ERRM_LSB = 12;
    localparam int STAT_ERRM_MSB = 15;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SCAN     = 3'd1,
        ST_DISPATCH = 3'd2,
        ST_WAIT     = 3'd3,
        ST_FINISH   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/wb_dsp_equation_sequencer_priority_pick.sv
// Lowest-set-bit encoder over the four pending equation slots.
// Purely combinational; vld is low when nothing is pending.
module wb_dsp_priority_pick (
    input  logic [3:0] req,
    output logic [1:0] idx,
    output logic       vld
);

    always_comb begin
        idx = 2'd0;
        vld = 1'b1;
        casez (req)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: vld = 1'b0;
        endcase
    end

endmodule

// File: rtl/wb_dsp_equation_sequencer.sv
// Runs up to four enabled equations on the shared engine in index order, one at a time,
// with a per-equation watchdog; reports done/error/abort status and a level interrupt.
module wb_dsp_equation_sequencer
    import wb_dsp_equation_sequencer_pkg::*;
#(
    parameter int                   dw        = 32,
    parameter int                   TIMEOUT_W = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 16'hFFFF
) (
    input  logic          wb_clk,
    input  logic          wb_rst_n,
    input  logic [dw-1:0] control_reg,
    input  logic [dw-1:0] equation0_address_reg,
    input  logic [dw-1:0] equation1_address_reg,
    input  logic [dw-1:0] equation2_address_reg,
    input  logic [dw-1:0] equation3_address_reg,
    output logic          eq_start,
    output logic [dw-1:0] eq_address,
    input  logic          eq_done,
    input  logic          eq_error,
    output logic [dw-1:0] status_reg,
    output logic          interrupt
);

    localparam logic [TIMEOUT_W-1:0] WD_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    seq_state_t           state_q, state_d;
    logic                 start_prev_q;
    logic [NUM_EQ-1:0]    pend_q, pend_d;
    logic [1:0]           idx_q, idx_d;
    logic [dw-1:0]        addr_q, addr_d;
    logic [TIMEOUT_W-1:0] wd_q, wd_d, wd_inc;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 abrt_q, abrt_d;
    logic [NUM_EQ-1:0]    cmpl_q, cmpl_d;
    logic [NUM_EQ-1:0]    errm_q, errm_d;

    logic                 start_req;
    logic                 abort_req;
    logic                 wd_expired;
    logic [1:0]           pick_idx;
    logic                 pick_vld;
    logic [dw-1:0]        pick_addr;
    logic                 unused_ctrl;

    assign unused_ctrl = ^{control_reg[dw-1:CTRL_MASK_MSB+1], control_reg[CTRL_RSVD]};

    assign start_req  = control_reg[CTRL_START] & ~start_prev_q;
    assign abort_req  = control_reg[CTRL_ABORT];
    assign wd_inc     = wd_q + WD_ONE;
    assign wd_expired = (TIMEOUT != '0) && (wd_inc == TIMEOUT);

    wb_dsp_priority_pick u_pick (
        .req (pend_q),
        .idx (pick_idx),
        .vld (pick_vld)
    );

    always_comb begin
        case (pick_idx)
            2'd1:    pick_addr = equation1_address_reg;
            2'd2:    pick_addr = equation2_address_reg;
            2'd3:    pick_addr = equation3_address_reg;
            default: pick_addr = equation0_address_reg;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        wd_d     = wd_q;
        done_d   = done_q;
        err_d    = err_q;
        abrt_d   = abrt_q;
        cmpl_d   = cmpl_q;
        errm_d   = errm_q;
        eq_start = 1'b0;

        // Abort overrides every other event, including a same-cycle completion.
        if (state_q != ST_IDLE && abort_req) begin
            abrt_d  = 1'b1;
            pend_d  = '0;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_req) begin
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        abrt_d  = 1'b0;
                        cmpl_d  = '0;
                        errm_d  = '0;
                        pend_d  = control_reg[CTRL_MASK_MSB:CTRL_MASK_LSB];
                        state_d = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (!pick_vld) begin
                        state_d = ST_FINISH;
                    end else begin
                        idx_d   = pick_idx;
                        addr_d  = pick_addr;
                        state_d = ST_DISPATCH;
                    end
                end
                ST_DISPATCH: begin
                    eq_start = 1'b1;
                    wd_d     = '0;
                    state_d  = ST_WAIT;
                end
                ST_WAIT: begin
                    if (eq_done) begin
                        cmpl_d[idx_q] = 1'b1;
                        if (eq_error) begin
                            errm_d[idx_q] = 1'b1;
                            err_d         = 1'b1;
                        end
                        pend_d[idx_q] = 1'b0;
                        state_d       = ST_SCAN;
                    end else if (wd_expired) begin
                        errm_d[idx_q] = 1'b1;
                        err_d         = 1'b1;
                        pend_d[idx_q] = 1'b0;
                        state_d       = ST_SCAN;
                    end else begin
                        wd_d = wd_inc;
                    end
                end
                ST_FINISH: begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b0;
            pend_q       <= '0;
            idx_q        <= '0;
            addr_q       <= '0;
            wd_q         <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            abrt_q       <= 1'b0;
            cmpl_q       <= '0;
            errm_q       <= '0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= control_reg[CTRL_START];
            pend_q       <= pend_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            wd_q         <= wd_d;
            done_q       <= done_d;
            err_q        <= err_d;
            abrt_q       <= abrt_d;
            cmpl_q       <= cmpl_d;
            errm_q       <= errm_d;
        end
    end

    assign eq_address = addr_q;
    assign interrupt  = control_reg[CTRL_IRQ_EN] & (done_q | err_q | abrt_q);

    always_comb begin
        status_reg                              = '0;
        status_reg[STAT_BUSY]                   = (state_q != ST_IDLE);
        status_reg[STAT_DONE]                   = done_q;
        status_reg[STAT_ERROR]                  = err_q;
        status_reg[STAT_ABORTED]                = abrt_q;
        status_reg[STAT_IDX_MSB:STAT_IDX_LSB]   = idx_q;
        status_reg[STAT_CMPL_MSB:STAT_CMPL_LSB] = cmpl_q;
        status_reg[STAT_ERRM_MSB:STAT_ERRM_LSB] = errm_q;
    end

endmodule
